// File: rtl/flex_pts_serializer_pkg.sv
// Shared types for the flex_pts parallel-to-serial transmitter.
package flex_pts_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/flex_pts_serializer_if.sv
// Word-load handshake between a producing controller and the serializer.
// A word moves on a rising clk edge where load_valid && load_ready. The producer keeps
// parallel_in stable while load_valid is high. load_ready does not depend on load_valid.
interface flex_pts_serializer_if #(
  parameter int NUM_BITS = 8
);
  logic                load_valid;
  logic                load_ready;
  logic [NUM_BITS-1:0] parallel_in;

  modport master (output load_valid, output parallel_in, input  load_ready);
  modport slave  (input  load_valid, input  parallel_in, output load_ready);
endinterface

// File: rtl/flex_pts_serializer_counter.sv
// Rollover counter: counts 0..rollover_val while enabled, then wraps to 0.
module flex_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         count_enable,
  input  logic [W-1:0] rollover_val,
  output logic [W-1:0] count_out
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) count_out <= '0;
      else                           count_out <= count_out + W'(1);
    end
  end

endmodule

// File: rtl/flex_pts_serializer.sv
// Parallel-to-serial transmitter with a one-word holding buffer, so frames can run
// back to back. Each bit is held CLKS_PER_BIT cycles. abort flushes everything.
module flex_pts_serializer
  import flex_pts_pkg::*;
#(
  parameter int   NUM_BITS     = 8,
  parameter int   SHIFT_MSB    = 1,
  parameter int   CLKS_PER_BIT = 1,
  parameter logic IDLE_BIT     = 1'b1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  flex_pts_serializer_if.slave   load_if,
  input  logic                   abort,
  output logic                   serial_out,
  output logic                   bit_strobe,
  output logic                   busy,
  output logic                   frame_done,
  output state_t                 dbg_state
);

  localparam int BW = $clog2(NUM_BITS);
  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]       LAST_BIT  = BW'(NUM_BITS - 1);
  localparam logic [PW-1:0]       PRESC_MAX = PW'(CLKS_PER_BIT - 1);
  localparam logic [NUM_BITS-1:0] FILL      = {NUM_BITS{IDLE_BIT}};

  state_t              state, state_n;
  logic [NUM_BITS-1:0] sr, hold, sr_shifted;
  logic                hold_full;
  logic [BW-1:0]       bit_cnt;
  logic [PW-1:0]       presc;
  logic                presc_term, accept;
  logic                load_sr, do_shift, last_bit;

  flex_counter #(.W(PW)) u_presc (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (abort || (state != SHIFT)),
    .count_enable (state == SHIFT),
    .rollover_val (PRESC_MAX),
    .count_out    (presc)
  );

  // With CLKS_PER_BIT=1 the rollover value is 0, so every SHIFT cycle is terminal.
  assign presc_term = (presc == PRESC_MAX);
  assign load_if.load_ready = !hold_full;
  assign accept     = load_if.load_valid && !hold_full && !abort;
  assign sr_shifted = (SHIFT_MSB != 0) ? {sr[NUM_BITS-2:0], IDLE_BIT}
                                       : {IDLE_BIT, sr[NUM_BITS-1:1]};
  assign serial_out = (state == SHIFT) ? ((SHIFT_MSB != 0) ? sr[NUM_BITS-1] : sr[0])
                                       : IDLE_BIT;
  assign busy       = (state == SHIFT);
  assign dbg_state  = state;

  always_comb begin
    state_n  = state;
    load_sr  = 1'b0;
    do_shift = 1'b0;
    last_bit = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (hold_full) begin
            load_sr = 1'b1;
            state_n = SHIFT;
          end
        end
        SHIFT: begin
          if (presc_term) begin
            if (bit_cnt == LAST_BIT) begin
              last_bit = 1'b1;
              // A buffered word continues straight on with no idle bit period.
              if (hold_full) load_sr = 1'b1;
              else           state_n = IDLE;
            end else begin
              do_shift = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr         <= FILL;
      hold       <= '0;
      hold_full  <= 1'b0;
      bit_cnt    <= '0;
      bit_strobe <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      bit_strobe <= load_sr || do_shift;
      frame_done <= last_bit;
      if (abort) begin
        sr        <= FILL;
        hold_full <= 1'b0;
        bit_cnt   <= '0;
      end else begin
        if (accept) begin
          hold      <= load_if.parallel_in;
          hold_full <= 1'b1;
        end else if (load_sr) begin
          hold_full <= 1'b0;
        end
        if (load_sr) begin
          sr      <= hold;
          bit_cnt <= '0;
        end else if (do_shift) begin
          sr      <= sr_shifted;
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_flex_pts_serializer.sv
// Bench for flex_pts_serializer: three configurations (MSB/8b/4cpb, LSB/8b/4cpb, MSB/4b/1cpb)
// compared cycle by cycle against a bit-sequence model built from the transmitted words.
module tb_flex_pts_serializer;
  import flex_pts_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [2:0] abort_v;
  logic [2:0] ser, stb, bsy, dn;
  state_t     st_a, st_b, st_c;
  int         n_total = 0;
  int         n_pass  = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  flex_pts_serializer_if #(.NUM_BITS(8)) if_a ();
  flex_pts_serializer_if #(.NUM_BITS(8)) if_b ();
  flex_pts_serializer_if #(.NUM_BITS(4)) if_c ();

  flex_pts_serializer #(.NUM_BITS(8), .SHIFT_MSB(1), .CLKS_PER_BIT(4), .IDLE_BIT(1'b1)) dut_a (
    .clk(clk), .n_rst(n_rst), .load_if(if_a), .abort(abort_v[0]), .serial_out(ser[0]),
    .bit_strobe(stb[0]), .busy(bsy[0]), .frame_done(dn[0]), .dbg_state(st_a));
  flex_pts_serializer #(.NUM_BITS(8), .SHIFT_MSB(0), .CLKS_PER_BIT(4), .IDLE_BIT(1'b1)) dut_b (
    .clk(clk), .n_rst(n_rst), .load_if(if_b), .abort(abort_v[1]), .serial_out(ser[1]),
    .bit_strobe(stb[1]), .busy(bsy[1]), .frame_done(dn[1]), .dbg_state(st_b));
  flex_pts_serializer #(.NUM_BITS(4), .SHIFT_MSB(1), .CLKS_PER_BIT(1), .IDLE_BIT(1'b1)) dut_c (
    .clk(clk), .n_rst(n_rst), .load_if(if_c), .abort(abort_v[2]), .serial_out(ser[2]),
    .bit_strobe(stb[2]), .busy(bsy[2]), .frame_done(dn[2]), .dbg_state(st_c));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  function automatic logic obs_ready(input int sel);
    case (sel)
      0:       return if_a.load_ready;
      1:       return if_b.load_ready;
      default: return if_c.load_ready;
    endcase
  endfunction

  function automatic logic obs_shift(input int sel);
    case (sel)
      0:       return st_a == SHIFT;
      1:       return st_b == SHIFT;
      default: return st_c == SHIFT;
    endcase
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] w);
    case (sel)
      0:       begin if_a.load_valid = v; if_a.parallel_in = w;      end
      1:       begin if_b.load_valid = v; if_b.parallel_in = w;      end
      default: begin if_c.load_valid = v; if_c.parallel_in = w[3:0]; end
    endcase
  endtask

  task automatic check_outs(input int sel, input string tag, input logic e_ser, input logic e_stb,
                            input logic e_bsy, input logic e_dn, input logic e_rdy);
    chk($sformatf("%s/serial", tag), ser[sel], e_ser);
    chk($sformatf("%s/strobe", tag), stb[sel], e_stb);
    chk($sformatf("%s/busy",   tag), bsy[sel], e_bsy);
    chk($sformatf("%s/done",   tag), dn[sel],  e_dn);
    chk($sformatf("%s/ready",  tag), obs_ready(sel), e_rdy);
    chk($sformatf("%s/state",  tag), obs_shift(sel), e_bsy);
  endtask

  // Model: the line carries word bits in transmit order, each for cpb cycles, starting one
  // cycle after the accept; a second word accepted mid-frame follows with no gap.
  task automatic run_frames(input int sel, input logic [7:0] w0, input logic [7:0] w1,
                            input bit two, input int acc, input string tag);
    int nb, cpb, flen, total, bi;
    bit msb;
    logic [7:0] word;
    logic eb;
    nb    = (sel == 2) ? 4 : 8;
    cpb   = (sel == 2) ? 1 : 4;
    msb   = (sel != 1);
    flen  = nb * cpb;
    total = two ? 2 * flen : flen;
    drive(sel, 1'b1, w0);
    tick();
    drive(sel, 1'b0, 8'h00);
    check_outs(sel, {tag, "/acc"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int n = 0; n < total; n++) begin
      word = (n >= flen) ? w1 : w0;
      bi   = (n % flen) / cpb;
      eb   = msb ? word[nb-1-bi] : word[bi];
      check_outs(sel, $sformatf("%s/c%0d", tag, n), eb, (n % cpb) == 0, 1'b1,
                 two && (n == flen), !(two && (n > acc) && (n < flen)));
      if (two && (n == acc)) drive(sel, 1'b1, w1);
      else                   drive(sel, 1'b0, 8'h00);
      tick();
    end
    check_outs(sel, {tag, "/end"},  1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check_outs(sel, {tag, "/post"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] w0, w1, w2;
    int bi;
    n_rst   = 1'b1;
    abort_v = 3'b000;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 8'h00);
    #1 n_rst = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) check_outs(s, $sformatf("reset%0d", s), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    n_rst = 1'b1;
    tick();

    // MSB-first directed and random frames
    run_frames(0, 8'hA5, 8'h00, 1'b0, 0, "msb_a5");
    repeat (3) run_frames(0, 8'($urandom), 8'h00, 1'b0, 0, "msb_rnd");

    // back to back
    run_frames(0, 8'hF0, 8'h0F, 1'b1, 5, "b2b_f0_0f");
    repeat (2) run_frames(0, 8'($urandom), 8'($urandom), 1'b1, $urandom_range(0, 30), "b2b_rnd");

    // LSB-first
    run_frames(1, 8'h01, 8'h00, 1'b0, 0, "lsb_01");
    repeat (2) run_frames(1, 8'($urandom), 8'h00, 1'b0, 0, "lsb_rnd");
    run_frames(1, 8'($urandom), 8'($urandom), 1'b1, $urandom_range(0, 30), "lsb_b2b");

    // one clock per bit, 4-bit frames
    run_frames(2, 8'h09, 8'h00, 1'b0, 0, "cpb1_1001");
    repeat (2) run_frames(2, 8'($urandom_range(0, 15)), 8'h00, 1'b0, 0, "cpb1_rnd");
    run_frames(2, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'b1,
               $urandom_range(0, 2), "cpb1_b2b");

    // abort in cycle 10 with the holding buffer full
    w0 = 8'($urandom);
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    drive(0, 1'b1, w0);
    tick();
    drive(0, 1'b0, 8'h00);
    tick();
    for (int n = 0; n <= 10; n++) begin
      bi = n / 4;
      check_outs(0, $sformatf("abort/c%0d", n), w0[7-bi], (n % 4) == 0, 1'b1, 1'b0, n <= 2);
      if (n == 2)       drive(0, 1'b1, w1);
      else if (n == 10) begin drive(0, 1'b1, w2); abort_v[0] = 1'b1; end
      else              drive(0, 1'b0, 8'h00);
      tick();
    end
    abort_v[0] = 1'b0;
    drive(0, 1'b0, 8'h00);
    check_outs(0, "abort/after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_outs(0, "abort/after2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frames(0, 8'($urandom), 8'h00, 1'b0, 0, "post_abort");

    // asynchronous reset mid-frame
    drive(0, 1'b1, 8'($urandom));
    tick();
    drive(0, 1'b0, 8'h00);
    repeat (14) tick();
    #2 n_rst = 1'b0;
    #1;
    check_outs(0, "rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    n_rst = 1'b1;
    tick();
    run_frames(0, 8'($urandom), 8'h00, 1'b0, 0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
